// File: rtl/cpu6_exu.sv
// cpu6_exu: execute stage. Combinational ALU feeding a 2-entry elastic
// buffer (main + skid). in_ready comes straight from a flop, so downstream
// backpressure never reaches decode combinationally.
module cpu6_exu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alucontrol,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_regwrite,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd,
  output logic            out_regwrite
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            ready_reg;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] main_result, skid_result;
  logic [RD_W-1:0] main_rd, skid_rd;
  logic            main_regwrite, skid_regwrite;
  logic            main_valid;
  logic            accept, transfer;
  logic            load_main_in, load_main_skid, load_skid;

  // ALU: unsigned SLT, unknown codes give zero
  always_comb begin
    alu_result = '0;
    case (alucontrol)
      3'b000:  alu_result = src_a & src_b;
      3'b001:  alu_result = src_a | src_b;
      3'b010:  alu_result = src_a + src_b;
      3'b110:  alu_result = src_a - src_b;
      3'b111:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_result = '0;
    endcase
  end

  // Handshake events; flush kills both sides
  assign main_valid = (state_reg == ONE) || (state_reg == FULL);
  assign accept     = in_valid & ready_reg & ~flush;
  assign transfer   = main_valid & out_ready & ~flush;

  // State register plus registered in_ready (high unless next state is FULL)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != FULL);
    end
  end

  // Next-state logic; flush dominates every other event
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = ONE;
        ONE: begin
          if (accept && !transfer)      state_next = FULL;
          else if (!accept && transfer) state_next = EMPTY;
        end
        FULL:    if (transfer) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output/datapath control: which registers load this cycle
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: load_main_in = accept;
      ONE: begin
        load_main_in = accept & transfer;
        load_skid    = accept & ~transfer;
      end
      FULL:  load_main_skid = transfer;
      default: ;
    endcase
  end

  // Main data register: loads only from input or from skid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_result   <= '0;
      main_rd       <= '0;
      main_regwrite <= 1'b0;
    end else if (load_main_in) begin
      main_result   <= alu_result;
      main_rd       <= in_rd;
      main_regwrite <= in_regwrite;
    end else if (load_main_skid) begin
      main_result   <= skid_result;
      main_rd       <= skid_rd;
      main_regwrite <= skid_regwrite;
    end
  end

  // Skid data register: catches an accept while main is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_result   <= '0;
      skid_rd       <= '0;
      skid_regwrite <= 1'b0;
    end else if (load_skid) begin
      skid_result   <= alu_result;
      skid_rd       <= in_rd;
      skid_regwrite <= in_regwrite;
    end
  end

  assign in_ready     = ready_reg;
  assign out_valid    = main_valid;
  assign out_result   = main_result;
  assign out_zero     = (main_result == '0);
  assign out_rd       = main_rd;
  assign out_regwrite = main_regwrite & main_valid;

endmodule

// File: tb/tb_cpu6_exu.sv
// Directed and randomized bench for cpu6_exu.
module tb_cpu6_exu;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_regwrite;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  cpu6_exu #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .src_a(src_a), .src_b(src_b),
    .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .out_regwrite(out_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic put(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic rw);
    alucontrol  = op;
    src_a       = a;
    src_b       = b;
    in_rd       = rd;
    in_regwrite = rw;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    put(3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
    checks++; if (out_rd !== 5'd0 || out_regwrite !== 1'b0) begin errors++; $display("FAIL reset_rd_rw got %0d/%b want 0/0", out_rd, out_regwrite); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_alu_ops;
    logic [2:0]  ops [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b111, 3'b011};
    logic [31:0] as  [7] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] bs  [7] = '{32'h1, 32'd7, 32'hFF00FF00, 32'h2, 32'hFFFFFFFF, 32'h1, 32'h9ABCDEF0};
    logic [31:0] exp [7] = '{32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'h3, 32'h1, 32'h0, 32'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      put(ops[i], as[i], bs[i], 5'(i + 1), 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i] || out_zero !== (exp[i] == 32'd0) ||
          out_rd !== 5'(i + 1) || out_regwrite !== 1'b1) begin
        errors++;
        $display("FAIL alu_op%0d got v=%b r=%h z=%b rd=%0d rw=%b want v=1 r=%h z=%b rd=%0d rw=1",
                 i, out_valid, out_result, out_zero, out_rd, out_regwrite, exp[i], exp[i] == 32'd0, i + 1);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain%0d out_valid got %b want 0", i, out_valid); end
    end
    $display("test_alu_ops done");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clk);
    put(3'b010, 32'd10, 32'd1, 5'd1, 1'b1); in_valid = 1'b1;            // A = 11
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %b want 1", in_ready); end
    put(3'b010, 32'd20, 32'd2, 5'd2, 1'b1);                              // B = 22
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_result !== 32'd11) begin errors++; $display("FAIL bp_full got ready=%b r=%0d want ready=0 r=11", in_ready, out_result); end
    put(3'b010, 32'd30, 32'd3, 5'd3, 1'b0);                              // C = 33 held
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd11 || out_rd !== 5'd1) begin errors++; $display("FAIL bp_hold got ready=%b v=%b r=%0d rd=%0d want 0/1/11/1", in_ready, out_valid, out_result, out_rd); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd22 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_out_b got v=%b r=%0d ready=%b want 1/22/1", out_valid, out_result, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd33 || out_regwrite !== 1'b0) begin errors++; $display("FAIL bp_out_c got v=%b r=%0d rw=%b want 1/33/0", out_valid, out_result, out_regwrite); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_streaming;
    logic [31:0] e;
    logic [4:0]  erd;
    logic [2:0]  op;
    logic [31:0] a, b;
    out_ready = 1'b1;
    e = '0; erd = '0;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== e || out_rd !== erd || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream%0d got v=%b r=%h rd=%0d ready=%b want 1/%h/%0d/1", i, out_valid, out_result, out_rd, in_ready, e, erd);
        end
      end
      if (i < 100) begin
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        put(op, a, b, 5'(i), 1'b1);
        in_valid = 1'b1;
        e = ref_alu(op, a, b); erd = 5'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    $display("test_streaming done");
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    @(negedge clk);
    put(3'b001, 32'h10, 32'h01, 5'd4, 1'b1); in_valid = 1'b1;
    @(negedge clk);
    put(3'b001, 32'h20, 32'h02, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b want 0", in_ready); end
    put(3'b010, 32'hDEAD0000, 32'h0000BEEF, 5'd6, 1'b1); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear got v=%b ready=%b want 0/1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got v=%b r=%h want v=0", out_valid, out_result); end
    put(3'b110, 32'd100, 32'd1, 5'd7, 1'b1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd99 || out_rd !== 5'd7) begin errors++; $display("FAIL flush_next got v=%b r=%0d rd=%0d want 1/99/7", out_valid, out_result, out_rd); end
    @(negedge clk);
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_stall;
    out_ready = 1'b0;
    @(negedge clk);
    put(3'b010, 32'd7, 32'd8, 5'd9, 1'b1); in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_setup got ready=%b v=%b want 0/1", in_ready, out_valid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0 || out_zero !== 1'b1 ||
        out_rd !== 5'd0 || out_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got v=%b ready=%b r=%h z=%b rd=%0d rw=%b want 0/1/0/1/0/0",
               out_valid, in_ready, out_result, out_zero, out_rd, out_regwrite);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    put(3'b010, 32'd2, 32'd3, 5'd1, 1'b1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_zero !== 1'b0) begin errors++; $display("FAIL rst_after_add got v=%b r=%0d z=%b want 1/5/0", out_valid, out_result, out_zero); end
    @(negedge clk);
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_random;
    ent_t q[$];
    ent_t n;
    logic [2:0]  op;
    logic [31:0] a, b;
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rand_ctl c=%0d got v=%b ready=%b want v=%b ready=%b", c, out_valid, in_ready, q.size() != 0, q.size() < 2);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_result !== q[0].res || out_zero !== (q[0].res == 32'd0) || out_rd !== q[0].rd || out_regwrite !== q[0].rw) begin
          errors++;
          $display("FAIL rand_data c=%0d got r=%h z=%b rd=%0d rw=%b want r=%h rd=%0d rw=%b",
                   c, out_result, out_zero, out_rd, out_regwrite, q[0].res, q[0].rd, q[0].rw);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      put(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        n.res = ref_alu(op, a, b); n.rd = in_rd; n.rw = in_regwrite;
        q.push_back(n);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
